cnn_conv_engine: RTL and testbench
==================================

# cnn_conv_engine

Parametrised single-channel convolution engine for the CNN chip. It loads a KER_N×KER_N signed kernel and an IMG_N×IMG_N signed image over a shared input bus. It computes the valid-region 2-D convolution, with optional ReLU and optional 2×2 max-pool, and streams the results out. The kernel is retained across frames, so it can be reused. It sits between the chip input pads and the classifier stage that drives the number_* outputs.

## Interface
- DATA_W, 15: signed width of kernel and pixel words.
- IMG_N, 6: image side length.
- KER_N, 3: kernel side length; must satisfy KER_N ≤ IMG_N.
- ACC_W, 2*DATA_W+$clog2(KER_N*KER_N): derived result width, full precision, signed.
- clk  in  1  single clock; all flops are on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid_1  in  1  kernel word strobe.
- in_valid_2  in  1  image word strobe.
- in_data  in  DATA_W  signed kernel or pixel word, raster order.
- relu_en  in  1  clamps negative conv results to 0.
- pool_en  in  1  enables 2×2 max-pool with stride 2.
- busy  out  1  high while a frame is loading, computing or outputting.
- out_valid  out  1  out_data is valid this cycle.
- out_data  out  ACC_W  signed result.

## Operation
- M = IMG_N-KER_N+1 conv outputs per side.
- Pool output side is M/2. Pooling is legal only when M is even; otherwise pool_en is treated as 0.
- FSM states: IDLE, LOAD_K, LOAD_I, CONV, OUT.
- IDLE:
  - in_valid_1 high → LOAD_K; that word is kernel[0].
  - Else in_valid_2 high → LOAD_I; that word is pixel[0], and relu_en/pool_en are latched.
  - If both strobes are high together, in_valid_1 wins and in_data goes to the kernel.
- LOAD_K: captures KER_N² words on in_valid_1 cycles only.
  - Gaps (strobe low) hold the word counter.
  - After the last word the FSM returns to IDLE.
  - in_valid_2 is ignored during LOAD_K.
- LOAD_I: captures IMG_N² words on in_valid_2 cycles only; gaps hold the counter.
  - After the last word the FSM goes to CONV.
  - in_valid_1 is ignored during LOAD_I.
- CONV: computes one result per cycle in raster order, M² cycles in total.
  - Each result is ΣK[i][j]·P[r+i][c+j] (correlation, no kernel flip), computed with KER_N² parallel signed multipliers.
  - If the latched relu_en is set, negative results are replaced by 0 before storage.
  - Results are stored in a result buffer of M² entries.
- OUT, pool off: emits M² buffer entries in raster order.
- OUT, pool on: emits (M/2)² entries; each is the max of a 2×2 block of the buffer, taken after ReLU.
- After the last output the FSM returns to IDLE. The kernel is kept, so a new image may follow immediately without reloading.
- Kernel storage resets to all zeros. An image sent with no kernel ever loaded produces all-zero results.
- Strobes received in CONV or OUT are ignored, and busy stays high.
- relu_en and pool_en are sampled only at the first image word; changes later in the frame have no effect.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, FSM=IDLE. Reset also clears the kernel, image and result buffers and all counters.
- rst_n asserted mid-frame, in any state, aborts the frame immediately with no further outputs.
- out_data is registered and is 0 whenever out_valid=0.
- busy rises in the cycle after the first accepted word and falls in the cycle after the last out_valid.
  - busy is also high during LOAD_K.
- Let t be the cycle of the last image word. CONV occupies t+1 … t+M².
- The first out_valid is at cycle t+M²+1.
- out_valid is then high for M² consecutive cycles without pool, or (M/2)² with pool; there are no gaps.
- Earliest next image word: the cycle after the last out_valid.

## Structure
- Package cnn_pkg holds:
  - the FSM state enum;
  - the default DATA_W/IMG_N/KER_N;
  - a function computing ACC_W;
  - a function computing M.
- One sub-module, cnn_mac_window: purely combinational KER_N² multiply-adder tree that returns the ACC_W-bit sum for one window.
- Buffers are plain register arrays; no SRAM.

## Test plan
- Kernel all 1, image all 1, defaults → 16 outputs, each 9; first out_valid 17 cycles after the last image word.
- Kernel with only the centre tap = 1, image pixel[k]=k for k=0..35 → outputs 7,8,9,10,13,14,15,16,19,20,21,22,25,26,27,28.
- Same kernel and image with pool_en=1 → 4 outputs: 14, 16, 26, 28.
- Kernel all -1, image all 1: relu_en=0 gives 16×(-9); relu_en=1 gives 16×0.
- Extremes: kernel all -16384, image all -16384 → every output 2415919104, with no overflow in 34 bits.
- Robustness, each case checked separately:
  - Random in_valid gaps during both loads give results identical to gap-free loading.
  - Back-to-back images reuse the kernel.
  - rst_n pulsed during CONV gives no out_valid, busy=0, and a zero kernel afterwards.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types, default parameters and derived-size helpers for the convolution engine.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    LOAD_I,
    CONV,
    OUT
  } state_t;

  localparam int unsigned DEF_DATA_W = 15;
  localparam int unsigned DEF_IMG_N  = 6;
  localparam int unsigned DEF_KER_N  = 3;

  // Full-precision width of a KER_N x KER_N signed dot product.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned ker_n);
    return 2 * data_w + $clog2(ker_n * ker_n);
  endfunction

  // Valid-region conv outputs per side.
  function automatic int unsigned conv_m(input int unsigned img_n, input int unsigned ker_n);
    return img_n - ker_n + 1;
  endfunction

  // Index width for an n-entry array, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_mac_window.sv
// Combinational KER_N^2 signed multiply-add over one kernel-sized window.
module cnn_mac_window
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned KER_N  = DEF_KER_N,
  parameter int unsigned ACC_W  = acc_w(DATA_W, KER_N)
) (
  input  logic [KER_N*KER_N*DATA_W-1:0] kernel,
  input  logic [KER_N*KER_N*DATA_W-1:0] window,
  output logic [ACC_W-1:0]              sum
);

  localparam int unsigned TAPS = KER_N * KER_N;
  localparam int unsigned PW   = 2 * DATA_W;

  logic signed [PW-1:0]    prod [TAPS];
  logic signed [ACC_W-1:0] acc;

  always_comb begin
    prod = '{default: '0};
    for (int unsigned t = 0; t < TAPS; t++) begin
      prod[t] = PW'(signed'(kernel[t*DATA_W +: DATA_W])) *
                PW'(signed'(window[t*DATA_W +: DATA_W]));
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned t = 0; t < TAPS; t++) begin
      acc = acc + ACC_W'(prod[t]);
    end
  end

  assign sum = acc;

endmodule

// File: rtl/cnn_conv_engine.sv
// Single-channel valid-region convolution with optional ReLU and 2x2 max-pool.
// The kernel persists across frames; results stream out after the whole frame is computed.
module cnn_conv_engine
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMG_N  = DEF_IMG_N,
  parameter int unsigned KER_N  = DEF_KER_N,
  parameter int unsigned ACC_W  = acc_w(DATA_W, KER_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic [DATA_W-1:0] in_data,
  input  logic              relu_en,
  input  logic              pool_en,
  output logic              busy,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data
);

  localparam int unsigned M       = conv_m(IMG_N, KER_N);
  localparam int unsigned PM      = M / 2;
  localparam int unsigned PM_S    = (PM == 0) ? 1 : PM;
  localparam int unsigned K_SZ    = KER_N * KER_N;
  localparam int unsigned I_SZ    = IMG_N * IMG_N;
  localparam int unsigned R_SZ    = M * M;
  localparam int unsigned KAW     = idx_w(K_SZ);
  localparam int unsigned IAW     = idx_w(I_SZ);
  localparam int unsigned RAW     = idx_w(R_SZ);
  localparam int unsigned MW      = idx_w(M);
  localparam int unsigned OW      = $clog2(R_SZ + 1);
  localparam bit          POOL_OK = (M % 2) == 0;

  logic signed [DATA_W-1:0] ker   [K_SZ];
  logic signed [DATA_W-1:0] img   [I_SZ];
  logic signed [ACC_W-1:0]  rbuf  [R_SZ];
  logic signed [ACC_W-1:0]  rview [R_SZ];

  state_t state, state_d;

  logic [KAW-1:0] k_cnt, k_widx;
  logic [IAW-1:0] i_cnt, i_widx;
  logic           k_last, i_last;
  logic [MW-1:0]  conv_r, conv_c;
  logic [RAW-1:0] conv_idx;
  logic           conv_last, conv_act;
  logic [OW-1:0]  o_idx, n_out, sel_o;
  logic           relu_q, pool_q;
  logic           k_we, i_we, latch_mode;
  logic           busy_d, out_valid_d;
  logic [ACC_W-1:0] out_data_d;

  logic [K_SZ*DATA_W-1:0]  ker_flat, win_flat;
  logic signed [ACC_W-1:0] mac_sum, conv_res, sel_data, m01, m23;

  function automatic logic signed [ACC_W-1:0] smax(input logic signed [ACC_W-1:0] a,
                                                   input logic signed [ACC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Buffer index of one corner of the 2x2 block feeding pooled output o.
  function automatic logic [RAW-1:0] pool_idx(input logic [OW-1:0] o, input int unsigned off);
    return RAW'(2 * (32'(o) / PM_S) * M + 2 * (32'(o) % PM_S) + off);
  endfunction

  // The first word of a load arrives in IDLE and always lands at index 0.
  assign k_widx    = (state == IDLE) ? '0 : k_cnt;
  assign i_widx    = (state == IDLE) ? '0 : i_cnt;
  assign k_last    = (k_widx == KAW'(K_SZ - 1));
  assign i_last    = (i_widx == IAW'(I_SZ - 1));
  assign conv_act  = (state == CONV);
  assign conv_last = (conv_idx == RAW'(R_SZ - 1));
  assign n_out     = pool_q ? OW'(PM * PM) : OW'(R_SZ);
  assign sel_o     = conv_act ? '0 : o_idx;

  always_comb begin
    ker_flat = '0;
    for (int unsigned t = 0; t < K_SZ; t++) begin
      ker_flat[t*DATA_W +: DATA_W] = ker[t];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned i = 0; i < KER_N; i++) begin
      for (int unsigned j = 0; j < KER_N; j++) begin
        win_flat[(i*KER_N+j)*DATA_W +: DATA_W] =
          img[IAW'((32'(conv_r) + i) * IMG_N + 32'(conv_c) + j)];
      end
    end
  end

  cnn_mac_window #(
    .DATA_W (DATA_W),
    .KER_N  (KER_N),
    .ACC_W  (ACC_W)
  ) u_mac (
    .kernel (ker_flat),
    .window (win_flat),
    .sum    (mac_sum)
  );

  assign conv_res = (relu_q && mac_sum[ACC_W-1]) ? '0 : mac_sum;

  // The first output is launched in the last CONV cycle, so forward the entry being written.
  always_comb begin
    for (int unsigned e = 0; e < R_SZ; e++) begin
      rview[e] = (conv_act && conv_idx == RAW'(e)) ? conv_res : rbuf[e];
    end
  end

  always_comb begin
    m01      = '0;
    m23      = '0;
    sel_data = rview[RAW'(sel_o)];
    if (pool_q) begin
      m01      = smax(rview[pool_idx(sel_o, 0)], rview[pool_idx(sel_o, 1)]);
      m23      = smax(rview[pool_idx(sel_o, M)], rview[pool_idx(sel_o, M + 1)]);
      sel_data = smax(m01, m23);
    end
  end

  always_comb begin
    state_d     = state;
    busy_d      = busy;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    k_we        = 1'b0;
    i_we        = 1'b0;
    latch_mode  = 1'b0;
    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (in_valid_1) begin
          k_we    = 1'b1;
          state_d = k_last ? IDLE : LOAD_K;
          busy_d  = !k_last;
        end else if (in_valid_2) begin
          i_we       = 1'b1;
          latch_mode = 1'b1;
          state_d    = i_last ? CONV : LOAD_I;
          busy_d     = 1'b1;
        end
      end
      LOAD_K: begin
        if (in_valid_1) begin
          k_we = 1'b1;
          if (k_last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      LOAD_I: begin
        if (in_valid_2) begin
          i_we = 1'b1;
          if (i_last) state_d = CONV;
        end
      end
      CONV: begin
        if (conv_last) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
        end
      end
      OUT: begin
        if (o_idx < n_out) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

  // Storage and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < K_SZ; t++) ker[t] <= '0;
      for (int unsigned t = 0; t < I_SZ; t++) img[t] <= '0;
      for (int unsigned t = 0; t < R_SZ; t++) rbuf[t] <= '0;
      k_cnt    <= '0;
      i_cnt    <= '0;
      conv_r   <= '0;
      conv_c   <= '0;
      conv_idx <= '0;
      o_idx    <= '0;
      relu_q   <= 1'b0;
      pool_q   <= 1'b0;
    end else begin
      if (k_we) begin
        ker[k_widx] <= in_data;
        k_cnt       <= k_last ? '0 : k_widx + KAW'(1);
      end
      if (i_we) begin
        img[i_widx] <= in_data;
        i_cnt       <= i_last ? '0 : i_widx + IAW'(1);
      end
      if (latch_mode) begin
        relu_q <= relu_en;
        pool_q <= pool_en & POOL_OK;
      end
      if (conv_act) begin
        rbuf[conv_idx] <= conv_res;
        if (conv_last) begin
          conv_idx <= '0;
          conv_r   <= '0;
          conv_c   <= '0;
          o_idx    <= OW'(1);
        end else begin
          conv_idx <= conv_idx + RAW'(1);
          if (conv_c == MW'(M - 1)) begin
            conv_c <= '0;
            conv_r <= conv_r + MW'(1);
          end else begin
            conv_c <= conv_c + MW'(1);
          end
        end
      end
      if (state == OUT) begin
        o_idx <= (o_idx < n_out) ? o_idx + OW'(1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Randomized scoreboard bench for cnn_conv_engine against a plain-arithmetic convolution model.
module tb_cnn_conv_engine;
  import cnn_pkg::*;

  localparam int DW  = DEF_DATA_W;
  localparam int N   = DEF_IMG_N;
  localparam int K   = DEF_KER_N;
  localparam int AW  = 2 * DW + $clog2(K * K);
  localparam int M   = N - K + 1;
  localparam int KSZ = K * K;
  localparam int ISZ = N * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid_1 = 1'b0;
  logic          in_valid_2 = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          relu_en = 1'b0;
  logic          pool_en = 1'b0;
  logic          busy;
  logic          out_valid;
  logic [AW-1:0] out_data;

  cnn_conv_engine #(
    .DATA_W (DW),
    .IMG_N  (N),
    .KER_N  (K)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_1 (in_valid_1),
    .in_valid_2 (in_valid_2),
    .in_data    (in_data),
    .relu_en    (relu_en),
    .pool_en    (pool_en),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     checks = 0;
  int     failures = 0;
  longint exp_q[$];
  int     last_edge = 0;
  bit     expect_first = 1'b0;
  bit     prev_ov = 1'b0;
  longint kmod[KSZ];
  longint imod[ISZ];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sres(input logic [AW-1:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic longint rnd();
    return longint'($urandom_range(0, (1 << DW) - 1)) - longint'(1 << (DW - 1));
  endfunction

  // Monitor: pops one expectation per out_valid cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid) begin
          if (expect_first) begin
            // Edge count from the last word's capture edge to the edge raising out_valid.
            chk("first_latency", longint'(cyc - last_edge), longint'(M * M));
            expect_first = 1'b0;
          end
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0d expected=none (cycle %0d)", sres(out_data), cyc);
          end else begin
            chk("out_data", sres(out_data), exp_q.pop_front());
          end
          chk("busy_during_out", longint'(busy), 1);
        end else begin
          chk("idle_data_zero", sres(out_data), 0);
          if (prev_ov) begin
            chk("out_gap_remaining", longint'(exp_q.size()), 0);
            chk("busy_fall", longint'(busy), 0);
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic push_model(input bit re, input bit pe);
    longint conv[M*M];
    longint s, mx, v;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < M; c++) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += kmod[i*K+j] * imod[(r+i)*N + c + j];
        if (re && s < 0) s = 0;
        conv[r*M+c] = s;
      end
    end
    if (pe && (M % 2 == 0)) begin
      for (int pr = 0; pr < M / 2; pr++) begin
        for (int pc = 0; pc < M / 2; pc++) begin
          mx = conv[(2*pr)*M + 2*pc];
          for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) begin
              v = conv[(2*pr+a)*M + 2*pc + b];
              if (v > mx) mx = v;
            end
          exp_q.push_back(mx);
        end
      end
    end else begin
      for (int e = 0; e < M * M; e++) exp_q.push_back(conv[e]);
    end
  endtask

  task automatic drive(input bit v1, input bit v2, input longint d, input bit re, input bit pe);
    @(negedge clk);
    in_valid_1 = v1;
    in_valid_2 = v2;
    in_data    = DW'(d);
    relu_en    = re;
    pool_en    = pe;
    last_edge  = cyc + 1;
  endtask

  // Idle cycles, optionally toggling strobes that the current state should ignore.
  task automatic gap(input int n, input bit noise1, input bit noise2);
    repeat (n) begin
      @(negedge clk);
      in_valid_1 = noise1 && ($urandom_range(0, 1) == 1);
      in_valid_2 = noise2 && ($urandom_range(0, 1) == 1);
      in_data    = DW'($urandom);
      relu_en    = ($urandom_range(0, 1) == 1);
      pool_en    = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic load_kernel(input bit gaps, input bit both_first);
    for (int k = 0; k < KSZ; k++) begin
      if (k > 0 && gaps) gap($urandom_range(0, 2), 1'b0, 1'b1);
      drive(1'b1, (k == 0) && both_first, kmod[k], 1'b0, 1'b0);
      if (k == 1) chk("busy_load_k", longint'(busy), 1);
    end
    gap(2, 1'b0, 1'b0);
    chk("busy_after_k", longint'(busy), 0);
  endtask

  task automatic send_image(input bit re, input bit pe, input bit gaps, input bit noise_conv,
                            input bit abort);
    bit done;
    int seen;
    push_model(re, pe);
    for (int k = 0; k < ISZ; k++) begin
      if (k > 0 && gaps) gap($urandom_range(0, 2), 1'b1, 1'b0);
      drive(1'b0, 1'b1, imod[k],
            (k == 0) ? re : ($urandom_range(0, 1) == 1),
            (k == 0) ? pe : ($urandom_range(0, 1) == 1));
    end
    expect_first = 1'b1;
    gap(noise_conv ? 5 : 1, noise_conv, noise_conv);
    gap(1, 1'b0, 1'b0);
    chk("busy_conv", longint'(busy), 1);
    if (abort) begin
      gap(2, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", longint'(busy), 0);
      chk("abort_valid", longint'(out_valid), 0);
      exp_q.delete();
      expect_first = 1'b0;
      for (int k = 0; k < KSZ; k++) kmod[k] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("abort_no_out", longint'(seen), 0);
      return;
    end
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk("frame_done", longint'(done), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data", sres(out_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-ones kernel and image.
    for (int k = 0; k < KSZ; k++) kmod[k] = 1;
    for (int k = 0; k < ISZ; k++) imod[k] = 1;
    load_kernel(1'b0, 1'b0);
    send_image(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Centre tap on a ramp image, first kernel word sent with both strobes high.
    for (int k = 0; k < KSZ; k++) kmod[k] = (k == KSZ / 2) ? 1 : 0;
    for (int k = 0; k < ISZ; k++) imod[k] = k;
    load_kernel(1'b0, 1'b1);
    send_image(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_image(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Negative kernel with and without ReLU.
    for (int k = 0; k < KSZ; k++) kmod[k] = -1;
    for (int k = 0; k < ISZ; k++) imod[k] = 1;
    load_kernel(1'b0, 1'b0);
    send_image(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_image(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Most negative operands everywhere.
    for (int k = 0; k < KSZ; k++) kmod[k] = -(longint'(1) << (DW - 1));
    for (int k = 0; k < ISZ; k++) imod[k] = -(longint'(1) << (DW - 1));
    load_kernel(1'b0, 1'b0);
    send_image(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_image(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random frames with load gaps, ignored strobes, and kernel reuse.
    repeat (6) begin
      for (int k = 0; k < KSZ; k++) kmod[k] = rnd();
      for (int k = 0; k < ISZ; k++) imod[k] = rnd();
      load_kernel(1'b1, 1'b0);
      send_image($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < ISZ; k++) imod[k] = rnd();
      send_image($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, 1'b0, 1'b0);
    end

    // Reset during CONV, then an image against the cleared kernel.
    for (int k = 0; k < KSZ; k++) kmod[k] = rnd();
    for (int k = 0; k < ISZ; k++) imod[k] = rnd();
    load_kernel(1'b0, 1'b0);
    send_image(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < ISZ; k++) imod[k] = 1;
    send_image(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
